// File: rtl/serdes_word_aligner.sv
// ---------------------------------------------------------------------------
// serdes_word_aligner
//
// Sits after the ISERDESE2 in the SERDES loopback path and runs on CLKDIV.
// It compares each deserialized word with TRAIN_PATTERN. It issues single
// BITSLIP pulses until the word lines up with the pattern, and then reports
// lock. While the link is locked, it watches for bad words: it counts them and
// drops back to hunting after LOSS_COUNT consecutive misses.
//
// Optional feature macro: SERDES_ALIGN_ERRCNT_EN
//   defined     -> ERR_CNT is a saturating count of mismatches seen while locked
//   not defined -> no counter is built and ERR_CNT is tied to zero
//   The port list, the FSM and the loss-of-lock logic are the same in both builds.
//
// Ports
//   CLKDIV   in   1           parallel-word clock (same net as ISERDESE2 CLKDIV)
//   RST      in   1           synchronous, active-high reset
//   DATA_IN  in   DATA_WIDTH  deserialized word, bit DATA_WIDTH-1 = Q1
//   RETRAIN  in   1           single-cycle request to restart alignment
//   BITSLIP  out  1           single-cycle pulse to ISERDESE2 BITSLIP
//   ALIGNED  out  1           high while locked
//   FAIL     out  1           sticky; MAX_SLIPS used up without reaching lock
//   ERR_CNT  out  16          saturating mismatch count while locked
//
// Parameters
//   DATA_WIDTH     parallel word width, matches the ISERDESE2 setting
//   TRAIN_PATTERN  training word; every rotation of it must be distinct
//   SETTLE_CYCLES  cycles DATA_IN is ignored after a slip or restart (>= 2)
//   MATCH_COUNT    consecutive matching words needed to declare lock
//   LOSS_COUNT     consecutive bad words while locked that force a relock
//   MAX_SLIPS      slips allowed without lock before FAIL (>= DATA_WIDTH)
// ---------------------------------------------------------------------------
module serdes_word_aligner #(
    parameter int                    DATA_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 8'hF0,
    parameter int                    SETTLE_CYCLES = 4,
    parameter int                    MATCH_COUNT   = 16,
    parameter int                    LOSS_COUNT    = 4,
    parameter int                    MAX_SLIPS     = 16
) (
    input  logic                  CLKDIV,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  RETRAIN,
    output logic                  BITSLIP,
    output logic                  ALIGNED,
    output logic                  FAIL,
    output logic [15:0]           ERR_CNT
);

    // Each counter is only as wide as the largest value it ever holds.
    // The settle, match and loss counters clear when they reach their terminal
    // value, so they never hold that value. The slip counter does hold
    // MAX_SLIPS, because it must report that value when the next mismatch arrives.
    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int MATCH_W  = (MATCH_COUNT   > 1) ? $clog2(MATCH_COUNT)   : 1;
    localparam int LOSS_W   = (LOSS_COUNT    > 1) ? $clog2(LOSS_COUNT)    : 1;
    localparam int SLIP_W   = $clog2(MAX_SLIPS + 1);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(MATCH_COUNT - 1);
    localparam logic [LOSS_W-1:0]   LOSS_LAST   = LOSS_W'(LOSS_COUNT - 1);
    localparam logic [SLIP_W-1:0]   SLIP_LIMIT  = SLIP_W'(MAX_SLIPS);

    typedef enum logic [2:0] {
        ST_SETTLE,
        ST_HUNT,
        ST_SLIP,
        ST_LOCKED,
        ST_FAILED
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [SETTLE_W-1:0] settle_q;
    logic [SETTLE_W-1:0] settle_d;
    logic [MATCH_W-1:0]  match_q;
    logic [MATCH_W-1:0]  match_d;
    logic [LOSS_W-1:0]   loss_q;
    logic [LOSS_W-1:0]   loss_d;
    logic [SLIP_W-1:0]   slip_q;
    logic [SLIP_W-1:0]   slip_d;
    logic                word_ok;

    assign word_ok = (DATA_IN == TRAIN_PATTERN);

    // Next-state and counter logic. RETRAIN overrides every transition,
    // including the loss-of-lock return to HUNT, and restarts from SETTLE with
    // all alignment counters cleared.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        match_d  = match_q;
        loss_d   = loss_q;
        slip_d   = slip_q;

        if (RETRAIN) begin
            state_d  = ST_SETTLE;
            settle_d = '0;
            match_d  = '0;
            loss_d   = '0;
            slip_d   = '0;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    // The word is unreliable while the ISERDES applies a slip.
                    if (settle_q == SETTLE_LAST) begin
                        settle_d = '0;
                        state_d  = ST_HUNT;
                    end else begin
                        settle_d = settle_q + SETTLE_W'(1);
                    end
                end

                ST_HUNT: begin
                    if (word_ok) begin
                        if (match_q == MATCH_LAST) begin
                            match_d = '0;
                            state_d = ST_LOCKED;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else begin
                        match_d = '0;
                        if (slip_q == SLIP_LIMIT) begin
                            state_d = ST_FAILED;
                        end else begin
                            slip_d  = slip_q + SLIP_W'(1);
                            state_d = ST_SLIP;
                        end
                    end
                end

                ST_SLIP: begin
                    // SLIP always lasts one cycle, so BITSLIP can never pulse
                    // twice in a row.
                    settle_d = '0;
                    state_d  = ST_SETTLE;
                end

                ST_LOCKED: begin
                    if (word_ok) begin
                        loss_d = '0;
                    end else if (loss_q == LOSS_LAST) begin
                        // Alignment is gone, but the bit offset is usually
                        // still close. Go straight back to hunting, with a
                        // fresh slip budget.
                        loss_d  = '0;
                        slip_d  = '0;
                        match_d = '0;
                        state_d = ST_HUNT;
                    end else begin
                        loss_d = loss_q + LOSS_W'(1);
                    end
                end

                ST_FAILED: begin
                    state_d = ST_FAILED;
                end

                default: begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end
            endcase
        end
    end

    // State register. The outputs are decoded from the next state so that they
    // come straight from flops and change on the same edge as the state.
    always_ff @(posedge CLKDIV) begin
        if (RST) begin
            state_q  <= ST_SETTLE;
            settle_q <= '0;
            match_q  <= '0;
            loss_q   <= '0;
            slip_q   <= '0;
            BITSLIP  <= 1'b0;
            ALIGNED  <= 1'b0;
            FAIL     <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            match_q  <= match_d;
            loss_q   <= loss_d;
            slip_q   <= slip_d;
            BITSLIP  <= (state_d == ST_SLIP);
            ALIGNED  <= (state_d == ST_LOCKED);
            FAIL     <= (state_d == ST_FAILED);
        end
    end

`ifdef SERDES_ALIGN_ERRCNT_EN
    logic        err_inc;
    logic [15:0] err_q;

    // Only locked-link errors are counted. RETRAIN keeps the count but does not
    // add the word sampled on that cycle to it.
    assign err_inc = !RETRAIN && (state_q == ST_LOCKED) && !word_ok;

    always_ff @(posedge CLKDIV) begin
        if (RST) begin
            err_q <= '0;
        end else if (err_inc && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign ERR_CNT = err_q;
`else
    assign ERR_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_serdes_word_aligner.sv
// ---------------------------------------------------------------------------
// tb_serdes_word_aligner
//
// Testbench for serdes_word_aligner.
//
// Channel model: the ISERDES output is TRAIN_PATTERN (or a constant word)
// rotated by a bit offset. Each BITSLIP pulse moves the offset by one bit, and
// the new offset reaches DATA_IN two cycles after the pulse is seen.
//
// Checking: the driver runs a reference model on every edge and pushes the
// expected outputs into a queue. A monitor on the falling edge pops the queue
// and compares against the DUT. A few scenario-level checks (pulse counts,
// lock timing, error totals) sit on top of that.
// ---------------------------------------------------------------------------
module tb_serdes_word_aligner;

    localparam logic [7:0] TRAIN  = 8'hF0;
    localparam int         SETTLE = 4;
    localparam int         MATCH  = 16;
    localparam int         LOSS   = 4;
    localparam int         MAXS   = 16;
`ifdef SERDES_ALIGN_ERRCNT_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic        clk_div  = 1'b0;
    logic        rst      = 1'b1;
    logic        retrain  = 1'b0;
    logic [7:0]  data_in  = 8'h00;
    logic        bitslip;
    logic        aligned;
    logic        fail;
    logic [15:0] err_cnt;

    always #5 clk_div = ~clk_div;

    serdes_word_aligner dut (
        .CLKDIV (clk_div),
        .RST    (rst),
        .DATA_IN(data_in),
        .RETRAIN(retrain),
        .BITSLIP(bitslip),
        .ALIGNED(aligned),
        .FAIL   (fail),
        .ERR_CNT(err_cnt)
    );

    typedef struct {
        logic        bitslip;
        logic        aligned;
        logic        fail;
        logic [15:0] err;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor bookkeeping for the scenario checks.
    int cycle_no    = 0;
    int slip_pulses = 0;
    int last_slip   = -1;
    int min_gap     = 1000;

    // Reference model state. It tracks the protocol with plain counters and
    // flags: a countdown of ignored cycles, a match run length, a slip budget,
    // and a run of consecutive losses.
    int m_settle_left = SETTLE;
    int m_matches     = 0;
    int m_slips       = 0;
    int m_losses      = 0;
    int m_err         = 0;
    bit m_locked      = 1'b0;
    bit m_failed      = 1'b0;
    bit m_slip_now    = 1'b0;

    // Channel state.
    logic [7:0] chan_src  = TRAIN;
    int         chan_off  = 0;
    logic [1:0] slip_pipe = 2'b00;

    function automatic logic [7:0] rotr(input logic [7:0] s, input int off);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = s[(i + off) % 8];
        return r;
    endfunction

    function automatic logic [7:0] rand_bad();
        logic [7:0] w;
        w = 8'($urandom);
        if (w == TRAIN) w = ~w;
        return w;
    endfunction

    task automatic model_clear(input bit also_err);
        m_settle_left = SETTLE;
        m_matches     = 0;
        m_slips       = 0;
        m_losses      = 0;
        m_locked      = 1'b0;
        m_failed      = 1'b0;
        m_slip_now    = 1'b0;
        if (also_err) m_err = 0;
    endtask

    task automatic model_step(input logic r, input logic rt, input logic [7:0] w);
        if (r) begin
            model_clear(1'b1);
        end else if (rt) begin
            model_clear(1'b0);
        end else if (m_failed) begin
            m_failed = 1'b1;
        end else if (m_slip_now) begin
            m_slip_now    = 1'b0;
            m_settle_left = SETTLE;
        end else if (m_settle_left > 0) begin
            m_settle_left--;
        end else if (m_locked) begin
            if (w != TRAIN) begin
                if (m_err < 65535) m_err++;
                m_losses++;
                if (m_losses == LOSS) begin
                    m_locked  = 1'b0;
                    m_losses  = 0;
                    m_slips   = 0;
                    m_matches = 0;
                end
            end else begin
                m_losses = 0;
            end
        end else begin
            if (w == TRAIN) begin
                m_matches++;
                if (m_matches == MATCH) begin
                    m_locked  = 1'b1;
                    m_matches = 0;
                end
            end else begin
                m_matches = 0;
                if (m_slips == MAXS) m_failed = 1'b1;
                else begin
                    m_slips++;
                    m_slip_now = 1'b1;
                end
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.bitslip = m_slip_now;
        e.aligned = m_locked;
        e.fail    = m_failed;
        e.err     = ERR_ON ? 16'(m_err) : 16'h0000;
        return e;
    endfunction

    // Drives one clock cycle: update the channel from BITSLIP, apply the
    // inputs, then step the model on the rising edge and queue its prediction.
    task automatic apply_stimulus(input logic r, input logic rt,
                                  input logic use_bad, input logic [7:0] bad_word);
        logic [7:0] w;
        @(negedge clk_div);
        slip_pipe = {slip_pipe[0], bitslip};
        if (slip_pipe[1]) chan_off = (chan_off + 7) % 8;
        w       = use_bad ? bad_word : rotr(chan_src, chan_off);
        rst     = r;
        retrain = rt;
        data_in = w;
        @(posedge clk_div);
        model_step(r, rt, w);
        sb_q.push_back(model_out());
    endtask

    task automatic set_channel(input logic [7:0] src, input int off);
        chan_src  = src;
        chan_off  = off;
        slip_pipe = 2'b00;
    endtask

    task automatic reset_dut(input logic [7:0] src, input int off);
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
        set_channel(src, off);
        slip_pulses = 0;
        last_slip   = -1;
        min_gap     = 1000;
    endtask

    task automatic run_good(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_val(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic check_output(input exp_t e);
        total++;
        if (bitslip !== e.bitslip || aligned !== e.aligned ||
            fail !== e.fail || err_cnt !== e.err) begin
            bad++;
            $display("[TB] FAIL outputs @cycle %0d: got bitslip=%b aligned=%b fail=%b err=%0d, expected bitslip=%b aligned=%b fail=%b err=%0d",
                     cycle_no, bitslip, aligned, fail, err_cnt,
                     e.bitslip, e.aligned, e.fail, e.err);
        end
    endtask

    // Monitor: samples on the falling edge, counts BITSLIP pulses and the
    // spacing between them, and checks each queued prediction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_div);
            cycle_no++;
            if (bitslip === 1'b1) begin
                slip_pulses++;
                if (last_slip >= 0 && (cycle_no - last_slip) < min_gap)
                    min_gap = cycle_no - last_slip;
                last_slip = cycle_no;
            end
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_output(e);
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        int first_align;
        int n;
        int snap;

        // Test 1: the stream is aligned from the start. There must be no slip.
        // ALIGNED rises on the 20th edge with RST low, i.e. it is high in the
        // 21st clock period counted from the one in which RST falls.
        $display("[TB] test 1: aligned stream");
        reset_dut(TRAIN, 0);
        first_align = 0;
        for (int c = 1; c <= 40; c++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
            #1;
            if (aligned === 1'b1 && first_align == 0) first_align = c;
        end
        check_val("t1 align edge", first_align, SETTLE + MATCH);
        check_val("t1 slip count", slip_pulses, 0);

        // Test 2: the stream is rotated by 3 (8'h1E). Three spaced slips, then lock.
        $display("[TB] test 2: rotated by 3");
        reset_dut(TRAIN, 3);
        run_good(60);
        #1;
        check_val("t2 slip count", slip_pulses, 3);
        check_val("t2 slip spacing ok", int'(min_gap >= SETTLE + 1), 1);
        check_val("t2 aligned", int'(aligned), 1);
        check_val("t2 fail", int'(fail), 0);

        // Test 3: constant 8'h00 input. The slip budget runs out, FAIL sticks,
        // and RETRAIN clears it.
        $display("[TB] test 3: constant zero input");
        reset_dut(8'h00, 0);
        run_good(130);
        #1;
        check_val("t3 slip count", slip_pulses, MAXS);
        check_val("t3 fail", int'(fail), 1);
        run_good(20);
        #1;
        check_val("t3 slips quiet", slip_pulses, MAXS);
        check_val("t3 fail sticky", int'(fail), 1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
        #1;
        check_val("t3 fail cleared", int'(fail), 0);

        // Test 4: while locked, send 3 bad words, 1 good word, then 4 bad words.
        $display("[TB] test 4: loss of lock");
        reset_dut(TRAIN, 0);
        run_good(25);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b1, rand_bad());
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b1, rand_bad());
        #1;
        check_val("t4 aligned before 4th", int'(aligned), 1);
        apply_stimulus(1'b0, 1'b0, 1'b1, rand_bad());
        #1;
        check_val("t4 aligned after 4th", int'(aligned), 0);
        check_val("t4 err count", int'(err_cnt), ERR_ON ? 7 : 0);
        run_good(20);
        #1;
        check_val("t4 relock", int'(aligned), 1);

        // Test 5: RETRAIN arrives in the same cycle the FSM leaves SLIP.
        $display("[TB] test 5: retrain during slip");
        reset_dut(8'h00, 0);
        n = 0;
        while (!m_slip_now && n < 40) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
            n++;
        end
        #1;
        check_val("t5 in slip", int'(bitslip), 1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
        snap = slip_pulses;
        run_good(SETTLE);
        @(negedge clk_div);
        #1;
        check_val("t5 no extra slip", slip_pulses, snap);

        // Test 6: reset while locked with 5 errors counted.
        $display("[TB] test 6: reset while locked");
        reset_dut(TRAIN, 0);
        run_good(25);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b1, rand_bad());
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++) apply_stimulus(1'b0, 1'b0, 1'b1, rand_bad());
        #1;
        check_val("t6 err before reset", int'(err_cnt), ERR_ON ? 5 : 0);
        check_val("t6 aligned before reset", int'(aligned), 1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
        #1;
        check_val("t6 aligned after reset", int'(aligned), 0);
        check_val("t6 err after reset", int'(err_cnt), 0);
        check_val("t6 fail after reset", int'(fail), 0);

        // Random phase: random offsets, injected bad words, and occasional
        // RETRAIN and RST pulses. Every cycle is checked against the model.
        $display("[TB] random phase");
        reset_dut(TRAIN, $urandom_range(7, 0));
        for (int i = 0; i < 1500; i++) begin
            logic r;
            logic rt;
            logic ub;
            r  = ($urandom_range(399, 0) == 0);
            rt = ($urandom_range(149, 0) == 0);
            ub = ($urandom_range(11, 0) == 0);
            apply_stimulus(r, rt, ub, rand_bad());
            if (r) set_channel(TRAIN, $urandom_range(7, 0));
        end

        @(negedge clk_div);
        #1;
        check_val("scoreboard drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
